// File: rtl/fht_control_gen.sv
// Address/enable sequencer for a 4-bank ping-pong FHT datapath of 2^N_LOG2 points.
// Optional FHT_CTRL_BITREV_EN folds the input bit-reversal into the stage-0 read order.
module fht_control_gen #(
  parameter int unsigned N_LOG2   = 10,
  parameter int unsigned A_BIT    = N_LOG2 - 2,
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned ST_BIT   = 5
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iSTART,
  input  logic              iABORT,
  output logic [ST_BIT-1:0] oSTAGE,
  output logic              oST_ZERO,
  output logic              oST_LAST,
  output logic [A_BIT-1:0]  oADDR_RD_0,
  output logic [A_BIT-1:0]  oADDR_RD_1,
  output logic [A_BIT-1:0]  oADDR_RD_2,
  output logic [A_BIT-1:0]  oADDR_RD_3,
  output logic              oRD_VALID,
  output logic [A_BIT-1:0]  oADDR_WR,
  output logic [A_BIT-1:0]  oADDR_COEF,
  output logic              oWE_A,
  output logic              oWE_B,
  output logic              oBUSY,
  output logic              oRDY
);

  localparam int unsigned D  = 1 << A_BIT;
  localparam int unsigned T  = D + PIPE_LAT;
  localparam int unsigned CW = A_BIT + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [CW-1:0]     r_cnt, w_cnt_d;
  logic [ST_BIT-1:0] r_s, w_s_d;

  logic [ST_BIT-1:0] r_stage;
  logic              r_st_zero, r_st_last, r_rd_valid, r_busy, r_rdy;
  logic [A_BIT-1:0]  r_rd [4];
  logic [A_BIT-1:0]  r_coef;
  logic [A_BIT-1:0]  r_dl_addr [PIPE_LAT];
  logic [PIPE_LAT-1:0] r_dl_wa, r_dl_wb;

  logic              w_run_d, w_valid_d;
  logic [A_BIT-1:0]  w_k, w_kr;
  int unsigned       w_r;
  logic [A_BIT-1:0]  w_rd_d [4];
  logic [A_BIT-1:0]  w_coef_d;

  function automatic logic [A_BIT-1:0] f_rotl(input logic [A_BIT-1:0] a, input int unsigned r);
    logic [A_BIT-1:0] o;
    o = '0;
    for (int unsigned i = 0; i < A_BIT; i++) o[(i + r) % A_BIT] = a[i];
    return o;
  endfunction

  function automatic logic [A_BIT-1:0] f_bitrev(input logic [A_BIT-1:0] a);
    logic [A_BIT-1:0] o;
    o = '0;
    for (int unsigned i = 0; i < A_BIT; i++) o[A_BIT-1-i] = a[i];
    return o;
  endfunction

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_s_d     = r_s;
    unique case (r_state)
      StIdle, StDone: begin
        if (iSTART) begin
          w_state_d = StRun;
          w_cnt_d   = '0;
          w_s_d     = '0;
        end
      end
      StRun: begin
        if (iABORT) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
          w_s_d     = '0;
        end else if (r_cnt == CW'(T - 1)) begin
          w_cnt_d = '0;
          if (r_s == ST_BIT'(N_LOG2 - 1)) begin
            w_state_d = StDone;
            w_s_d     = '0;
          end else begin
            w_s_d = r_s + ST_BIT'(1);
          end
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are computed from next-state values so each register matches its cycle's cnt/s.
  always_comb begin
    w_run_d   = (w_state_d == StRun);
    w_valid_d = w_run_d && (w_cnt_d < CW'(D));
    w_k       = w_cnt_d[A_BIT-1:0];
    w_r       = 32'(w_s_d) % A_BIT;
`ifdef FHT_CTRL_BITREV_EN
    w_kr = (w_s_d == '0) ? f_bitrev(w_k) : w_k;
`else
    w_kr = w_k;
`endif
    for (int j = 0; j < 4; j++) begin
      w_rd_d[j] = w_valid_d ? f_rotl(w_kr + A_BIT'(j * (D / 4)), w_r) : '0;
    end
    w_coef_d = '0;
    for (int unsigned i = 0; i < A_BIT; i++) begin
      if (i < w_r) w_coef_d[A_BIT - w_r + i] = w_k[i];
    end
    if (!w_valid_d) w_coef_d = '0;
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_s        <= '0;
      r_stage    <= '0;
      r_st_zero  <= 1'b0;
      r_st_last  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_coef     <= '0;
      r_busy     <= 1'b0;
      r_rdy      <= 1'b0;
      for (int j = 0; j < 4; j++) r_rd[j] <= '0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_s        <= w_s_d;
      r_stage    <= w_run_d ? w_s_d : '0;
      r_st_zero  <= w_run_d && (w_s_d == '0);
      r_st_last  <= w_run_d && (w_s_d == ST_BIT'(N_LOG2 - 1));
      r_rd_valid <= w_valid_d;
      r_coef     <= w_coef_d;
      r_busy     <= w_run_d;
      r_rdy      <= (w_state_d == StDone);
      for (int j = 0; j < 4; j++) r_rd[j] <= w_rd_d[j];
    end
  end

  // Delay line: buffer select travels with the address, so the stage bit never has to be delayed.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_dl_wa <= '0;
      r_dl_wb <= '0;
      for (int i = 0; i < PIPE_LAT; i++) r_dl_addr[i] <= '0;
    end else if (!w_run_d) begin
      r_dl_wa <= '0;
      r_dl_wb <= '0;
      for (int i = 0; i < PIPE_LAT; i++) r_dl_addr[i] <= '0;
    end else begin
      r_dl_addr[0] <= r_rd[0];
      r_dl_wa[0]   <= r_rd_valid & r_stage[0];
      r_dl_wb[0]   <= r_rd_valid & ~r_stage[0];
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_dl_addr[i] <= r_dl_addr[i-1];
        r_dl_wa[i]   <= r_dl_wa[i-1];
        r_dl_wb[i]   <= r_dl_wb[i-1];
      end
    end
  end

  assign oSTAGE     = r_stage;
  assign oST_ZERO   = r_st_zero;
  assign oST_LAST   = r_st_last;
  assign oADDR_RD_0 = r_rd[0];
  assign oADDR_RD_1 = r_rd[1];
  assign oADDR_RD_2 = r_rd[2];
  assign oADDR_RD_3 = r_rd[3];
  assign oRD_VALID  = r_rd_valid;
  assign oADDR_COEF = r_coef;
  assign oADDR_WR   = r_dl_addr[PIPE_LAT-1];
  assign oWE_A      = r_dl_wa[PIPE_LAT-1];
  assign oWE_B      = r_dl_wb[PIPE_LAT-1];
  assign oBUSY      = r_busy;
  assign oRDY       = r_rdy;

endmodule

// File: tb/tb_fht_control_gen.sv
// Randomized bench for fht_control_gen (N_LOG2=6, PIPE_LAT=3) against a cycle-index model.
module tb_fht_control_gen;

  localparam int N_LOG2 = 6;
  localparam int A      = 4;
  localparam int P      = 3;
  localparam int D      = 16;
  localparam int T      = D + P;

  logic       iCLK, iRESET, iSTART, iABORT;
  logic [4:0] oSTAGE;
  logic       oST_ZERO, oST_LAST, oRD_VALID, oWE_A, oWE_B, oBUSY, oRDY;
  logic [3:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3, oADDR_WR, oADDR_COEF;

  fht_control_gen #(.N_LOG2(N_LOG2), .A_BIT(A), .PIPE_LAT(P), .ST_BIT(5)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iABORT(iABORT),
    .oSTAGE(oSTAGE), .oST_ZERO(oST_ZERO), .oST_LAST(oST_LAST),
    .oADDR_RD_0(oADDR_RD_0), .oADDR_RD_1(oADDR_RD_1), .oADDR_RD_2(oADDR_RD_2),
    .oADDR_RD_3(oADDR_RD_3), .oRD_VALID(oRD_VALID), .oADDR_WR(oADDR_WR),
    .oADDR_COEF(oADDR_COEF), .oWE_A(oWE_A), .oWE_B(oWE_B), .oBUSY(oBUSY), .oRDY(oRDY)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int errors = 0;
  int checks = 0;
  int m_state = 0;  // 0 idle, 1 run, 2 done
  int m_t     = 0;  // cycles since the start edge, minus one

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int bitrev4(input int k);
    int o = 0;
    for (int i = 0; i < A; i++) if (((k >> i) & 1) != 0) o |= 1 << (A - 1 - i);
    return o;
  endfunction

  function automatic int exp_rd(input int j, input int s, input int c);
    int k, x, r;
    if (c >= D) return 0;
    k = c;
`ifdef FHT_CTRL_BITREV_EN
    if (s == 0) k = bitrev4(k);
`endif
    x = (k + j * D / 4) % D;
    r = s % A;
    return ((x << r) | (x >> (A - r))) & (D - 1);
  endfunction

  function automatic int exp_coef(input int s, input int c);
    int r = s % A;
    if (c >= D || r == 0) return 0;
    return (c & ((1 << r) - 1)) << (A - r);
  endfunction

  task automatic compare_all();
    int s, c;
    bit run;
    run = (m_state == 1);
    s = run ? m_t / T : 0;
    c = run ? m_t % T : 0;
    check("busy", oBUSY, int'(run));
    check("rdy", oRDY, int'(m_state == 2));
    check("stage", oSTAGE, s);
    check("st_zero", oST_ZERO, int'(run && s == 0));
    check("st_last", oST_LAST, int'(run && s == N_LOG2 - 1));
    check("rd_valid", oRD_VALID, int'(run && c < D));
    check("rd0", oADDR_RD_0, run ? exp_rd(0, s, c) : 0);
    check("rd1", oADDR_RD_1, run ? exp_rd(1, s, c) : 0);
    check("rd2", oADDR_RD_2, run ? exp_rd(2, s, c) : 0);
    check("rd3", oADDR_RD_3, run ? exp_rd(3, s, c) : 0);
    check("coef", oADDR_COEF, run ? exp_coef(s, c) : 0);
    check("addr_wr", oADDR_WR, (run && c >= P) ? exp_rd(0, s, c - P) : 0);
    check("we_b", oWE_B, int'(run && c >= P && s % 2 == 0));
    check("we_a", oWE_A, int'(run && c >= P && s % 2 == 1));
    if (run && c == 1) begin
      if (s == 1) begin
        check("s1c1_rd", {oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3}, 16'h2A3B);
        check("s1c1_coef", oADDR_COEF, 8);
      end
      if (s == 4) check("s4c1_rd", {oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3}, 16'h159D);
`ifdef FHT_CTRL_BITREV_EN
      if (s == 0) check("s0c1_rd", {oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3}, 16'h8C04);
`else
      if (s == 0) check("s0c1_rd", {oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3}, 16'h159D);
`endif
    end
  endtask

  task automatic model_update(input logic st, input logic ab);
    if (m_state != 1) begin
      if (st) begin
        m_state = 1;
        m_t = 0;
      end
    end else if (ab) begin
      m_state = 0;
    end else if (m_t == N_LOG2 * T - 1) begin
      m_state = 2;
    end else begin
      m_t++;
    end
  endtask

  // Called at a negedge: apply inputs over one rising edge, then compare at the next negedge.
  task automatic cycle(input logic st, input logic ab);
    iSTART = st;
    iABORT = ab;
    @(posedge iCLK);
    model_update(st, ab);
    @(negedge iCLK);
    iSTART = 1'b0;
    iABORT = 1'b0;
    compare_all();
  endtask

  task automatic do_reset();
    iSTART = 1'b0;
    iABORT = 1'b0;
    #3 iRESET = 1'b0;
    m_state = 0;
    m_t = 0;
    #1 compare_all();
    @(negedge iCLK);
    iRESET = 1'b1;
    compare_all();
  endtask

  task automatic run_full();
    int busy = 0;
    int lat = 1;
    cycle(1'b1, 1'b0);
    while (!oRDY && lat < 300) begin
      if (oBUSY) busy++;
      cycle(($urandom % 4) == 0, 1'b0);
      lat++;
    end
    check("busy_cycles", busy, N_LOG2 * T);
    check("rdy_latency", lat, N_LOG2 * T + 1);
    repeat (3) cycle(1'b0, ($urandom % 2) == 1);
  endtask

  task automatic run_to(input int t_target);
    int n = 0;
    while (!(m_state == 1 && m_t == t_target) && n < 300) begin
      cycle(1'b0, 1'b0);
      n++;
    end
  endtask

  initial begin
    iRESET = 1'b0;
    iSTART = 1'b0;
    iABORT = 1'b0;
    repeat (2) @(negedge iCLK);
    compare_all();
    iRESET = 1'b1;
    cycle(1'b0, 1'b1);

    run_full();

    cycle(1'b1, 1'b0);
    run_to(2 * T + 7);
    cycle(1'b0, 1'b1);
    check("abort_rdy", oRDY, 0);
    run_full();

    cycle(1'b1, 1'b0);
    run_to(3 * T + 5);
    do_reset();
    run_full();

    cycle(1'b1, 1'b0);
    run_to(T + 4);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b0);

    for (int it = 0; it < 8; it++) begin
      int len = 20 + int'($urandom % 150);
      for (int n = 0; n < len; n++) begin
        cycle(($urandom % 5) == 0, ($urandom % 70) == 0);
      end
      if (($urandom % 3) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
